// File: rtl/keypad_scanner_pkg.sv
// Shared constants and the row/column to key-code map for the keypad front end.
package keypad_pkg;
   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;

   localparam logic [3:0] KEY_NONE  = 4'hF;
   localparam logic [3:0] KEY_STAR  = 4'd10;
   localparam logic [3:0] KEY_SHARP = 4'd11;

   // Rows 0-2 are the digits 1-9; the bottom row is "* 0 #".
   function automatic logic [3:0] key_of(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (row == 2'd3) begin
         case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_SHARP;
         endcase
      end else begin
         code = 4'(3 * row + col + 1);
      end
      return code;
   endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side row/column wires plus the clean key bus delivered to the safe core.
interface keypad_scanner_if;
   import keypad_pkg::*;

   logic [NUM_COLS-1:0] col_in;
   logic [NUM_ROWS-1:0] row_drive;
   logic                key_valid;
   logic [3:0]          key_code;
   logic                key_held;
   logic [NUM_ROWS-1:0] row_out;
   logic [NUM_COLS-1:0] col_out;

   modport master (input col_in,
                   output row_drive, key_valid, key_code, key_held, row_out, col_out);
   modport slave  (output col_in,
                   input row_drive, key_valid, key_code, key_held, row_out, col_out);
endinterface

// File: rtl/keypad_debounce.sv
// Per-scan debounce: a candidate must repeat DEBOUNCE_SCANS scans before it is committed.
module keypad_debounce import keypad_pkg::*; #(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scan_done,
   input  logic [3:0] candidate,
   input  logic [3:0] committed,
   output logic       commit
);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

   logic [3:0]    prev;
   logic [CW-1:0] cnt, cnt_next;

   always_comb begin
      if (candidate != prev)  cnt_next = CW'(1);
      else if (cnt == CNT_MAX) cnt_next = cnt;
      else                     cnt_next = cnt + 1'b1;
      commit = scan_done && (cnt_next == CNT_MAX) && (candidate != committed);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= KEY_NONE;
         cnt  <= '0;
      end else if (scan_done) begin
         prev <= candidate;
         cnt  <= cnt_next;
      end
   end
endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: row strobing, column sync, ghost rejection and registered key outputs.
module keypad_scanner import keypad_pkg::*; #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input logic              clk,
   input logic              reset,
   keypad_scanner_if.master kp
);
   localparam int DW = $clog2(SCAN_DIV);

   logic [NUM_COLS-1:0]                 col_meta, col_sync;
   logic [DW-1:0]                       dwell;
   logic [1:0]                          row_idx;
   logic [NUM_ROWS-2:0][NUM_COLS-1:0]   scan_map;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0]   full_map;
   logic                                sample, scan_done, commit, single;
   logic [3:0]                          hits, cand;
   logic [1:0]                          hit_r, hit_c;
   logic [NUM_ROWS-1:0]                 cand_row;
   logic [NUM_COLS-1:0]                 cand_col;

   assign sample       = (dwell == DW'(SCAN_DIV - 1));
   assign scan_done    = sample && (row_idx == 2'd3);
   assign kp.row_drive = NUM_ROWS'(1) << row_idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         col_meta <= '0;
         col_sync <= '0;
         dwell    <= '0;
         row_idx  <= '0;
         scan_map <= '0;
      end else begin
         col_meta <= kp.col_in;
         col_sync <= col_meta;
         if (sample) begin
            dwell   <= '0;
            row_idx <= row_idx + 1'b1;
            if (row_idx != 2'd3) scan_map[row_idx] <= col_sync;
         end else begin
            dwell <= dwell + 1'b1;
         end
      end
   end

   // The last row is used straight from the synchronizer in its sample cycle.
   always_comb begin
      full_map = {col_sync, scan_map};
      hits     = '0;
      hit_r    = '0;
      hit_c    = '0;
      for (int r = 0; r < NUM_ROWS; r++)
         for (int c = 0; c < NUM_COLS; c++)
            if (full_map[r][c]) begin
               hits  = hits + 1'b1;
               hit_r = 2'(r);
               hit_c = 2'(c);
            end
      single   = (hits == 4'd1);
      cand     = single ? key_of(hit_r, hit_c) : KEY_NONE;
      cand_row = single ? NUM_ROWS'(1) << hit_r : '0;
      cand_col = single ? NUM_COLS'(1) << hit_c : '0;
   end

   keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .scan_done (scan_done),
      .candidate (cand),
      .committed (kp.key_code),
      .commit    (commit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         kp.key_valid <= 1'b0;
         kp.key_code  <= KEY_NONE;
         kp.key_held  <= 1'b0;
         kp.row_out   <= '0;
         kp.col_out   <= '0;
      end else begin
         kp.key_valid <= commit && (cand != KEY_NONE);
         if (commit) begin
            kp.key_code <= cand;
            kp.key_held <= (cand != KEY_NONE);
            kp.row_out  <= cand_row;
            kp.col_out  <= cand_col;
         end
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Scan-level bench: a keypad model, a scan-history reference model, and scenario tasks.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int SCAN     = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] pressed = '0;
   logic [2:0]  cols;

   int errors = 0;
   int checks = 0;
   int tot_pulses = 0;

   // Reference model state: recent per-scan candidates and the committed key.
   logic [3:0] hist[$];
   logic [3:0] m_code = 4'hF;
   logic [3:0] code_tab [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                 4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};

   keypad_scanner_if kp_if ();

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp_if)
   );

   always #5 clk = ~clk;

   // Pressed key at bit r*3+c pulls column c high while row r is strobed.
   always_comb begin
      cols = '0;
      for (int r = 0; r < 4; r++)
         if (kp_if.row_drive[r] === 1'b1) cols = cols | pressed[r*3 +: 3];
   end
   assign kp_if.col_in = cols;

   function automatic int bit_of(input logic [3:0] code);
      for (int i = 0; i < 12; i++) if (code_tab[i] == code) return i;
      return -1;
   endfunction

   function automatic logic [11:0] kbit(input logic [3:0] code);
      logic [11:0] one;
      one = 12'd1;
      return one << bit_of(code);
   endfunction

   function automatic logic [3:0] exp_row(input logic [3:0] code);
      if (code == 4'hF) return 4'b0000;
      return 4'(1 << (bit_of(code) / 3));
   endfunction

   function automatic logic [2:0] exp_col(input logic [3:0] code);
      if (code == 4'hF) return 3'b000;
      return 3'(1 << (bit_of(code) % 3));
   endfunction

   task automatic model_reset();
      hist.delete();
      m_code = 4'hF;
   endtask

   // One full scan from a scan-aligned negedge; checks against the model at the end.
   task automatic run_scan(input logic [11:0] keys, input string tag);
      logic [3:0] cand;
      logic       stable, exp_valid;
      int         rd_bad, mid;
      pressed = keys;
      cand = 4'hF;
      if ($countones(keys) == 1)
         for (int i = 0; i < 12; i++) if (keys[i]) cand = code_tab[i];
      hist.push_back(cand);
      if (hist.size() > DEB) void'(hist.pop_front());
      stable = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] != cand) stable = 1'b0;
      exp_valid = 1'b0;
      if (stable && cand != m_code) begin
         m_code    = cand;
         exp_valid = (cand != 4'hF);
      end
      rd_bad = 0;
      mid    = 0;
      for (int cyc = 1; cyc <= SCAN; cyc++) begin
         @(negedge clk);
         if (kp_if.row_drive !== 4'(1 << ((cyc / SCAN_DIV) % 4))) rd_bad++;
         if (kp_if.key_valid === 1'b1) tot_pulses++;
         if (cyc < SCAN && kp_if.key_valid !== 1'b0) mid++;
      end
      checks++; if (rd_bad != 0)
         $display("FAIL %s row_drive: %0d bad cycles, required 0", tag, rd_bad);
      checks++; if (mid != 0)
         $display("FAIL %s strobe_mid: %0d stray pulse cycles, required 0", tag, mid);
      checks++; if (kp_if.key_valid !== exp_valid)
         $display("FAIL %s key_valid: got %b required %b", tag, kp_if.key_valid, exp_valid);
      checks++; if (kp_if.key_code !== m_code)
         $display("FAIL %s key_code: got %h required %h", tag, kp_if.key_code, m_code);
      checks++; if (kp_if.key_held !== (m_code != 4'hF))
         $display("FAIL %s key_held: got %b required %b", tag, kp_if.key_held, m_code != 4'hF);
      checks++; if (kp_if.row_out !== exp_row(m_code))
         $display("FAIL %s row_out: got %b required %b", tag, kp_if.row_out, exp_row(m_code));
      checks++; if (kp_if.col_out !== exp_col(m_code))
         $display("FAIL %s col_out: got %b required %b", tag, kp_if.col_out, exp_col(m_code));
      errors += int'(rd_bad != 0) + int'(mid != 0) + int'(kp_if.key_valid !== exp_valid)
              + int'(kp_if.key_code !== m_code) + int'(kp_if.key_held !== (m_code != 4'hF))
              + int'(kp_if.row_out !== exp_row(m_code)) + int'(kp_if.col_out !== exp_col(m_code));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      checks++;
      if (kp_if.row_drive !== 4'b0001 || kp_if.key_code !== 4'hF || kp_if.key_valid !== 1'b0 ||
          kp_if.key_held !== 1'b0 || kp_if.row_out !== 4'b0 || kp_if.col_out !== 3'b0) begin
         errors++;
         $display("FAIL reset_values: got rd=%b code=%h v=%b h=%b ro=%b co=%b required 0001 f 0 0 0000 000",
                  kp_if.row_drive, kp_if.key_code, kp_if.key_valid, kp_if.key_held,
                  kp_if.row_out, kp_if.col_out);
      end
      run_scan('0, "idle0");
      run_scan('0, "idle1");
   endtask

   task automatic test_press5();
      int p0;
      p0 = tot_pulses;
      repeat (6) run_scan(kbit(4'd5), "press5");
      checks++;
      if (kp_if.key_code !== 4'd5 || kp_if.row_out !== 4'b0010 || kp_if.col_out !== 3'b010) begin
         errors++;
         $display("FAIL press5_const: got code=%h ro=%b co=%b required 5 0010 010",
                  kp_if.key_code, kp_if.row_out, kp_if.col_out);
      end
      repeat (4) run_scan('0, "release5");
      checks++;
      if (tot_pulses - p0 != 1) begin
         errors++;
         $display("FAIL press5_pulses: got %0d required 1", tot_pulses - p0);
      end
   endtask

   task automatic test_bounce();
      int p0;
      p0 = tot_pulses;
      for (int s = 0; s < 5; s++) run_scan((s % 2 == 0) ? kbit(4'd8) : 12'd0, "bounce");
      repeat (2) run_scan('0, "bounce_idle");
      checks++;
      if (tot_pulses != p0) begin
         errors++;
         $display("FAIL bounce_pulses: got %0d required 0", tot_pulses - p0);
      end
   endtask

   task automatic test_ghost();
      int p0;
      p0 = tot_pulses;
      repeat (5) run_scan(kbit(4'd1) | kbit(4'd2), "ghost");
      checks++;
      if (tot_pulses != p0 || kp_if.key_code !== 4'hF) begin
         errors++;
         $display("FAIL ghost: got pulses=%0d code=%h required 0 f", tot_pulses - p0, kp_if.key_code);
      end
      repeat (2) run_scan('0, "ghost_idle");
   endtask

   task automatic test_rollover();
      int p0;
      p0 = tot_pulses;
      repeat (5) run_scan(kbit(KEY_SHARP), "roll_sharp");
      checks++;
      if (kp_if.col_out !== 3'b100 || kp_if.key_code !== 4'd11) begin
         errors++;
         $display("FAIL roll_sharp: got co=%b code=%h required 100 b", kp_if.col_out, kp_if.key_code);
      end
      repeat (5) run_scan(kbit(KEY_STAR), "roll_star");
      checks++;
      if (kp_if.col_out !== 3'b001 || kp_if.key_code !== 4'd10) begin
         errors++;
         $display("FAIL roll_star: got co=%b code=%h required 001 a", kp_if.col_out, kp_if.key_code);
      end
      repeat (4) run_scan('0, "roll_release");
      checks++;
      if (tot_pulses - p0 != 2) begin
         errors++;
         $display("FAIL roll_pulses: got %0d required 2", tot_pulses - p0);
      end
   endtask

   task automatic test_reset_held();
      int p0;
      repeat (5) run_scan(kbit(4'd7), "hold7");
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (kp_if.key_code !== 4'hF || kp_if.key_held !== 1'b0 || kp_if.key_valid !== 1'b0 ||
          kp_if.row_out !== 4'b0 || kp_if.col_out !== 3'b0 || kp_if.row_drive !== 4'b0001) begin
         errors++;
         $display("FAIL reset_held: got code=%h h=%b v=%b ro=%b co=%b rd=%b required f 0 0 0000 000 0001",
                  kp_if.key_code, kp_if.key_held, kp_if.key_valid, kp_if.row_out,
                  kp_if.col_out, kp_if.row_drive);
      end
      reset = 1'b0;
      model_reset();
      p0 = tot_pulses;
      repeat (4) run_scan(kbit(4'd7), "rehold7");
      checks++;
      if (tot_pulses - p0 != 1) begin
         errors++;
         $display("FAIL reset_recommit: got %0d pulses required 1", tot_pulses - p0);
      end
      repeat (4) run_scan('0, "release7");
   endtask

   task automatic test_random();
      logic [11:0] cur, one;
      int sel;
      cur = '0;
      one = 12'd1;
      for (int s = 0; s < 40; s++) begin
         sel = $urandom_range(0, 9);
         if (sel >= 5 && sel <= 6) cur = one << $urandom_range(0, 11);
         else if (sel >= 7 && sel <= 8) cur = '0;
         else if (sel == 9) cur = (one << $urandom_range(0, 11)) | (one << $urandom_range(0, 11));
         run_scan(cur, "random");
      end
      repeat (4) run_scan('0, "random_idle");
   endtask

   initial begin
      test_reset();
      test_press5();
      test_bounce();
      test_ghost();
      test_rollover();
      test_reset_held();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
